// File: rtl/maj_pkg.sv
// Shared definitions for the oversampling front end and its majority consumer:
// window size, collector FSM encoding and the 3-input majority function.
package maj_pkg;

    localparam int SAMPLES = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } tsc_state_e;

    function automatic logic maj3(input logic [SAMPLES-1:0] w);
        return (w[2] & w[1]) | (w[2] & w[0]) | (w[1] & w[0]);
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample tick generator: free-running 0..CLKS_PER_SAMPLE-1 counter while en is high,
// tick asserted in the last count of each period.
module sample_tick_gen #(
    parameter int CLKS_PER_SAMPLE = 4,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_SAMPLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/tri_sample_collector.sv
// Collects three evenly spaced samples of din into a window offered on a valid/ready port.
// Optional registered majority vote of each accepted window when TSC_VOTE_EN is defined.
module tri_sample_collector
    import maj_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    output logic [2:0] win,
    output logic       win_valid,
    input  logic       win_ready,
    output logic       overflow,
    input  logic       clr_ovf,
    output logic       vote
);

    logic       sync1_q, sync2_q;
    logic       tick;
    logic [1:0] shreg_q, shreg_d;
    logic [1:0] idx_q, idx_d;
    logic [2:0] win_q, win_d;
    logic       valid_q, valid_d;
    logic       ovf_q, ovf_d;
    logic       ovf_set;
    logic       hs;
    tsc_state_e state_q, state_d;

    sample_tick_gen #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE),
        .CNT_W          (CNT_W)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    assign hs = valid_q & win_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        win_d   = win_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        ovf_set = 1'b0;

        if (hs) begin
            valid_d = 1'b0;
        end

        if (!en) begin
            state_d = IDLE;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: state_d = COLLECT;
                COLLECT, HOLD: begin
                    if (hs) begin
                        state_d = COLLECT;
                    end
                    if (tick) begin
                        shreg_d = {shreg_q[0], sync2_q};
                        if (idx_q == 2'd2) begin
                            // Completed window: drop it if the previous one is still unaccepted.
                            idx_d   = 2'd0;
                            state_d = HOLD;
                            if (valid_q && !win_ready) begin
                                ovf_set = 1'b1;
                            end else begin
                                win_d   = {shreg_q, sync2_q};
                                valid_d = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TSC_VOTE_EN
    logic vote_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_q <= 1'b0;
        end else if (hs) begin
            vote_q <= maj3(win_q);
        end
    end

    assign vote = vote_q;
`else
    assign vote = 1'b0;
`endif

    assign win       = win_q;
    assign win_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_tri_sample_collector.sv
// Directed bench for tri_sample_collector with a window scoreboard checked at each handshake.
module tb_tri_sample_collector;
    import maj_pkg::*;

    logic       clk = 1'b0;
    logic       rst, en, din, win_ready, clr_ovf;
    logic [2:0] win;
    logic       win_valid, overflow, vote;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cc    = 0;
    logic [7:0] sb    = '0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    tri_sample_collector #(
        .CLKS_PER_SAMPLE(4),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .win      (win),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .vote     (vote)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_vote(input logic [2:0] w);
`ifdef TSC_VOTE_EN
        return maj3(w);
`else
        return 1'b0;
`endif
    endfunction

    // Sample j is taken from din driven during cycles 4j..4j+3 (tick 4j+3 sees din of 4j+1).
    task automatic adv();
        @(posedge clk);
        #2;
        cc++;
        din = sb[(cc / 4) % 8];
    endtask

    task automatic upto(input int c);
        while (cc < c) adv();
    endtask

    task automatic start(input logic [7:0] bits);
        sb  = bits;
        cc  = 0;
        din = sb[0];
        en  = 1'b1;
    endtask

    task automatic quiesce();
        en        = 1'b0;
        win_ready = 1'b0;
        clr_ovf   = 1'b0;
        adv();
        adv();
    endtask

    always @(negedge clk) begin
        if (!rst && win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_window", {1'b0, win}, 4'hF);
            end else begin
                chk("sb_win", {1'b0, win}, {1'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; din = 1'b0; win_ready = 1'b0; clr_ovf = 1'b0;
        #3;
        chk("rst_win", {1'b0, win}, 4'h0);
        chk("rst_valid", {3'b0, win_valid}, 4'h0);
        chk("rst_ovf", {3'b0, overflow}, 4'h0);
        chk("rst_vote", {3'b0, vote}, 4'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        adv();

        // All-ones line, consumer always ready.
        start(8'hFF);
        win_ready = 1'b1;
        exp_q.push_back(3'b111);
        upto(11); chk("t1_valid_c11", {3'b0, win_valid}, 4'h0);
        upto(12); chk("t1_valid_c12", {3'b0, win_valid}, 4'h1);
        chk("t1_win_c12", {1'b0, win}, 4'h7);
        upto(13); chk("t1_valid_c13", {3'b0, win_valid}, 4'h0);
        chk("t1_vote_c13", {3'b0, vote}, {3'b0, exp_vote(3'b111)});
        quiesce();

        // 1,0,1 held by a stalled consumer, then accepted at cycle 20.
        start(8'b0000_0101);
        exp_q.push_back(3'b101);
        upto(12); chk("t2_valid_c12", {3'b0, win_valid}, 4'h1);
        chk("t2_win_c12", {1'b0, win}, 4'h5);
        upto(16); chk("t2_win_c16", {1'b0, win}, 4'h5);
        upto(19); chk("t2_valid_c19", {3'b0, win_valid}, 4'h1);
        chk("t2_win_c19", {1'b0, win}, 4'h5);
        upto(20); win_ready = 1'b1;
        upto(21); chk("t2_valid_c21", {3'b0, win_valid}, 4'h0);
        chk("t2_vote_c21", {3'b0, vote}, {3'b0, exp_vote(3'b101)});
        quiesce();

        // Second window while first pending: dropped, overflow, set beats clear.
        start(8'b0001_1100);
        exp_q.push_back(3'b001);
        upto(12); chk("t3_win_c12", {1'b0, win}, 4'h1);
        chk("t3_ovf_c12", {3'b0, overflow}, 4'h0);
        upto(23); clr_ovf = 1'b1;
        upto(24); chk("t3_win_c24", {1'b0, win}, 4'h1);
        chk("t3_valid_c24", {3'b0, win_valid}, 4'h1);
        chk("t3_ovf_set_beats_clr", {3'b0, overflow}, 4'h1);
        upto(25); chk("t3_ovf_cleared", {3'b0, overflow}, 4'h0);
        clr_ovf = 1'b0; win_ready = 1'b1;
        upto(26); chk("t3_valid_c26", {3'b0, win_valid}, 4'h0);
        chk("t3_vote_c26", {3'b0, vote}, {3'b0, exp_vote(3'b001)});
        quiesce();

        // Accept lands on the same edge the next window completes.
        start(8'b0011_0001);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b011);
        upto(12); chk("t4_win_c12", {1'b0, win}, 4'h4);
        upto(23); win_ready = 1'b1;
        upto(24); chk("t4_win_c24", {1'b0, win}, 4'h3);
        chk("t4_valid_c24", {3'b0, win_valid}, 4'h1);
        chk("t4_ovf_c24", {3'b0, overflow}, 4'h0);
        chk("t4_vote_c24", {3'b0, vote}, {3'b0, exp_vote(3'b100)});
        upto(25); chk("t4_valid_c25", {3'b0, win_valid}, 4'h0);
        chk("t4_vote_c25", {3'b0, vote}, {3'b0, exp_vote(3'b011)});
        quiesce();

        // en drops after two ticks; the window after re-enable holds only new samples.
        start(8'hFF);
        win_ready = 1'b1;
        upto(8); en = 1'b0;
        upto(12); chk("t5_valid_off", {3'b0, win_valid}, 4'h0);
        upto(13);
        start(8'b0000_0110);
        exp_q.push_back(3'b011);
        upto(11); chk("t5_valid_c11", {3'b0, win_valid}, 4'h0);
        upto(12); chk("t5_valid_c12", {3'b0, win_valid}, 4'h1);
        upto(13); chk("t5_vote_c13", {3'b0, vote}, {3'b0, exp_vote(3'b011)});
        quiesce();

        // Asynchronous reset while holding a window with overflow set.
        start(8'hFF);
        upto(24); chk("t6_ovf_c24", {3'b0, overflow}, 4'h1);
        chk("t6_valid_c24", {3'b0, win_valid}, 4'h1);
        upto(25);
        rst = 1'b1;
        #1;
        chk("t6_rst_win", {1'b0, win}, 4'h0);
        chk("t6_rst_valid", {3'b0, win_valid}, 4'h0);
        chk("t6_rst_ovf", {3'b0, overflow}, 4'h0);
        chk("t6_rst_vote", {3'b0, vote}, 4'h0);
        en = 1'b0;
        adv();
        rst = 1'b0;
        adv();
        chk("t6_valid_after_rst", {3'b0, win_valid}, 4'h0);
        chk("sb_drain", 4'(exp_q.size()), 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
